// File: rtl/ras_commit.sv
// Committed return-address stack with a handshaked restore of the frontend RAS.
// Optional return hit/miss counters are enabled by defining RAS_COMMIT_STATS_EN.
package config_pkg;
    localparam int VLEN = 32;
    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] ra;
    } ras_t;
endpackage

module ras_commit #(
    parameter int  DEPTH = 2,
    parameter type ras_t = config_pkg::ras_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      commit_call_i,
    input  logic                      commit_ret_i,
    input  logic [config_pkg::VLEN-1:0] commit_ra_i,
    input  logic [config_pkg::VLEN-1:0] commit_tgt_i,
    input  logic                      flush_i,
    output logic                      restore_valid_o,
    input  logic                      restore_ready_i,
    output logic [$clog2(DEPTH)-1:0]  restore_idx_o,
    output ras_t                      restore_data_o,
    output logic                      restore_busy_o,
    output logic                      restore_done_o,
    output logic                      ret_hit_o,
    output logic                      ret_miss_o,
    output logic [31:0]               ret_hit_cnt_o,
    output logic [31:0]               ret_miss_cnt_o
);
    import config_pkg::*;

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RESTORE,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    ras_t            stack_q [DEPTH];
    ras_t            stack_d [DEPTH];
    ras_t            snap_q  [DEPTH];
    logic            take_snap;
    logic            hit_d, miss_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];
        if (commit_call_i && !commit_ret_i) begin
            for (int i = DEPTH-1; i > 0; i--) stack_d[i] = stack_q[i-1];
            stack_d[0].valid = 1'b1;
            stack_d[0].ra    = commit_ra_i;
        end else if (commit_ret_i && !commit_call_i) begin
            for (int i = 0; i < DEPTH-1; i++) stack_d[i] = stack_q[i+1];
            stack_d[DEPTH-1] = '0;
        end else if (commit_call_i && commit_ret_i) begin
            stack_d[0].valid = 1'b1;
            stack_d[0].ra    = commit_ra_i;
        end
    end

    // Outcome is judged against the top entry before this cycle's commit.
    assign hit_d  = commit_ret_i && stack_q[0].valid &&
                    (stack_q[0].ra == commit_tgt_i);
    assign miss_d = commit_ret_i && !hit_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        take_snap = 1'b0;
        if (flush_i) begin
            state_d   = RESTORE;
            idx_d     = '0;
            take_snap = 1'b1;
        end else begin
            case (state_q)
                RESTORE: begin
                    if (restore_ready_i) begin
                        if (idx_q == IW'(DEPTH-1)) state_d = DONE;
                        else idx_d = idx_q + IW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ret_hit_o  <= 1'b0;
            ret_miss_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
                snap_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ret_hit_o  <= hit_d;
            ret_miss_o <= miss_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
                if (take_snap) snap_q[i] <= stack_d[i];
            end
        end
    end

    assign restore_valid_o = (state_q == RESTORE);
    assign restore_done_o  = (state_q == DONE);
    assign restore_busy_o  = (state_q != IDLE);
    assign restore_idx_o   = idx_q;
    assign restore_data_o  = snap_q[idx_q];

`ifdef RAS_COMMIT_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Counters advance together with the pulse they count and saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_d && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_d && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign ret_hit_cnt_o  = hit_cnt_q;
    assign ret_miss_cnt_o = miss_cnt_q;
`else
    assign ret_hit_cnt_o  = '0;
    assign ret_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ras_commit.sv
// Testbench for ras_commit: vector table, directed restore sequences and
// randomized traffic against a queue-based reference model.
module tb_ras_commit;
    import config_pkg::*;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst, call, ret, flush, ready;
    logic [31:0] ra, tgt;
    logic        rvalid, rbusy, rdone, hit, miss;
    logic [0:0]  ridx;
    ras_t        rdata;
    logic [31:0] hcnt, mcnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ras_commit #(.DEPTH(D)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .commit_call_i  (call),
        .commit_ret_i   (ret),
        .commit_ra_i    (ra),
        .commit_tgt_i   (tgt),
        .flush_i        (flush),
        .restore_valid_o(rvalid),
        .restore_ready_i(ready),
        .restore_idx_o  (ridx),
        .restore_data_o (rdata),
        .restore_busy_o (rbusy),
        .restore_done_o (rdone),
        .ret_hit_o      (hit),
        .ret_miss_o     (miss),
        .ret_hit_cnt_o  (hcnt),
        .ret_miss_cnt_o (mcnt)
    );

    // reference model: stack as a queue of valid addresses, top at index 0
    logic [31:0] mq[$];
    logic [32:0] msnap [D];
    int          phase;
    int          pos;
    logic        mhit, mmiss;
    logic [31:0] mhc, mmc;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic model_step();
        logic h;
        if (rst) begin
            mq.delete();
            for (int k = 0; k < D; k++) msnap[k] = '0;
            phase = 0; pos = 0; mhit = 0; mmiss = 0; mhc = 0; mmc = 0;
        end else begin
            h = ret && mq.size() > 0 && mq[0] == tgt;
            mhit = h;
            mmiss = ret && !h;
            if (mhit && mhc != 32'hFFFF_FFFF) mhc++;
            if (mmiss && mmc != 32'hFFFF_FFFF) mmc++;
            if (call && !ret) begin
                mq.push_front(ra);
                if (mq.size() > D) void'(mq.pop_back());
            end else if (ret && !call) begin
                if (mq.size() > 0) void'(mq.pop_front());
            end else if (call && ret) begin
                if (mq.size() == 0) mq.push_front(ra);
                else mq[0] = ra;
            end
            if (flush) begin
                for (int k = 0; k < D; k++)
                    msnap[k] = (k < mq.size()) ? {1'b1, mq[k]} : 33'd0;
                phase = 1; pos = 0;
            end else if (phase == 1) begin
                if (ready) begin
                    if (pos == D-1) phase = 2;
                    else pos++;
                end
            end else if (phase == 2) begin
                phase = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("m_valid", 64'(rvalid), 64'(phase == 1));
        chk("m_busy",  64'(rbusy),  64'(phase != 0));
        chk("m_done",  64'(rdone),  64'(phase == 2));
        chk("m_hit",   64'(hit),    64'(mhit));
        chk("m_miss",  64'(miss),   64'(mmiss));
`ifdef RAS_COMMIT_STATS_EN
        chk("m_hcnt", 64'(hcnt), 64'(mhc));
        chk("m_mcnt", 64'(mcnt), 64'(mmc));
`else
        chk("m_hcnt", 64'(hcnt), 64'd0);
        chk("m_mcnt", 64'(mcnt), 64'd0);
`endif
        if (phase == 1) begin
            chk("m_idx",  64'(ridx),  64'(pos));
            chk("m_data", 64'(rdata), 64'(msnap[pos]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic r, input logic c, input logic rt,
                         input logic [31:0] a, input logic [31:0] t,
                         input logic f, input logic rd);
        rst = r; call = c; ret = rt; ra = a; tgt = t; flush = f; ready = rd;
    endtask

    typedef struct {
        logic        rst, call, ret;
        logic [31:0] ra, tgt;
        logic        flush, ready;
        logic        ev;
        int          eidx;
        logic [32:0] edata;
        logic        edone, ehit, emiss;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic c, logic rt, logic [31:0] a,
                                logic [31:0] t, logic f, logic ev, int ei,
                                logic [32:0] ed, logic dn, logic h, logic m);
        vec_t v;
        v.rst = r; v.call = c; v.ret = rt; v.ra = a; v.tgt = t;
        v.flush = f; v.ready = 1'b1; v.ev = ev; v.eidx = ei;
        v.edata = ed; v.edone = dn; v.ehit = h; v.emiss = m;
        return v;
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 1);
        phase = 0; pos = 0;

        tv.push_back(mk(1, 0, 0, 0,        0,        0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 32'h1000, 0,        0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0,        32'h1000, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(1, 0, 0, 0,        0,        0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0,        32'h2000, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 0, 0, 0,        0,        0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 32'hA0,   0,        0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 32'hB0,   0,        0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,        0,        1, 1, 0, {1'b1, 32'hB0}, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,        0,        0, 1, 1, {1'b1, 32'hA0}, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,        0,        0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 0,        32'hB0,   0, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 1, 0,        32'h55,   0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0,        0,        0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].call, tv[i].ret, tv[i].ra, tv[i].tgt,
                  tv[i].flush, tv[i].ready);
            cycle();
            chk("tv_valid", 64'(rvalid), 64'(tv[i].ev));
            chk("tv_done",  64'(rdone),  64'(tv[i].edone));
            chk("tv_hit",   64'(hit),    64'(tv[i].ehit));
            chk("tv_miss",  64'(miss),   64'(tv[i].emiss));
            if (tv[i].ev) begin
                chk("tv_idx",  64'(ridx),  64'(tv[i].eidx));
                chk("tv_data", 64'(rdata), 64'(tv[i].edata));
            end
            if (i == 4) begin
`ifdef RAS_COMMIT_STATS_EN
                chk("tv_miss_cnt", 64'(mcnt), 64'd1);
`else
                chk("tv_miss_cnt", 64'(mcnt), 64'd0);
`endif
            end
        end

        // backpressure with a concurrent call
        drive(1, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 0, 32'h10, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 1, 0); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, k == 0, 0, 32'h20, 0, 0, 0);
            cycle();
            chk("bp_idx",  64'(ridx),  64'd0);
            chk("bp_data", 64'(rdata), {31'd0, 1'b1, 32'h10});
        end
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        chk("bp_idx1",  64'(ridx),  64'd1);
        chk("bp_data1", 64'(rdata), 64'd0);

        // flush while DONE
        cycle();
        chk("dn_done", 64'(rdone), 64'd1);
        drive(0, 0, 0, 0, 0, 1, 1); cycle();
        chk("dn_valid", 64'(rvalid), 64'd1);
        chk("dn_done2", 64'(rdone),  64'd0);
        chk("dn_idx",   64'(ridx),   64'd0);
        chk("dn_data",  64'(rdata),  {31'd0, 1'b1, 32'h20});

        // reset in the middle of a restore
        drive(1, 0, 0, 0, 0, 0, 1); cycle();
        chk("rs_valid", 64'(rvalid), 64'd0);
        chk("rs_busy",  64'(rbusy),  64'd0);
        drive(0, 0, 0, 0, 0, 1, 1); cycle();
        chk("rs_slot0", 64'(rdata), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        chk("rs_slot1", 64'(rdata), 64'd0);
        cycle();

        // randomized traffic
        drive(1, 0, 0, 0, 0, 0, 1); cycle();
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom % 64) == 0;
            call  = ($urandom % 3) == 0;
            ret   = ($urandom % 3) == 0;
            ra    = 32'h100 + 32'($urandom % 8);
            if (($urandom % 2 == 1) && mq.size() > 0) tgt = mq[0];
            else tgt = 32'h100 + 32'($urandom % 8);
            flush = ($urandom % 10) == 0;
            ready = ($urandom % 2) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
